// File: rtl/wave_plot_pkg.sv
// Shared types, colours and timing helpers for the wave plot video source
// and other video sources built on video_timing_gen.
package wave_plot_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t BG_COLOUR   = 24'heeeeee;
   localparam rgb_t GRID_COLOUR = 24'hbbbbbb;

   // One colour per channel lane; up to eight channels.
   localparam rgb_t PALETTE [8] = '{
      24'hd62728, 24'h1f77b4, 24'h2ca02c, 24'hff7f0e,
      24'h9467bd, 24'h8c564b, 24'he377c2, 24'h17becf
   };

   // Total pixels per line or lines per frame.
   function automatic int unsigned timing_total(input int unsigned sync_w,
                                                input int unsigned back_w,
                                                input int unsigned active_w,
                                                input int unsigned front_w);
      return sync_w + back_w + active_w + front_w;
   endfunction

   // First counter value of the active region.
   function automatic int unsigned timing_start(input int unsigned sync_w,
                                                input int unsigned back_w);
      return sync_w + back_w;
   endfunction

endpackage

// File: rtl/wave_plot_generator_video_timing_gen.sv
// video_timing_gen: free-running horizontal/vertical counters with
// combinational sync, data-enable, active coordinates and frame-start strobe.
// Ports:
//   clock, reset      pixel clock, synchronous active-high reset
//   hsync_c, vsync_c  active-high syncs for the current counter value
//   de_c              inside active pixels and active lines
//   v_active_c        inside active lines (any h)
//   frame_start_c     h == 0 && v == 0
//   x_c, y_c          counters minus sync+back porch (valid while de_c)
module video_timing_gen
   import wave_plot_pkg::*;
#(
   parameter int unsigned HSYNC   = 40,
   parameter int unsigned HBACK   = 220,
   parameter int unsigned HACTIVE = 1280,
   parameter int unsigned HFRONT  = 110,
   parameter int unsigned VSYNC   = 5,
   parameter int unsigned VBACK   = 20,
   parameter int unsigned VACTIVE = 720,
   parameter int unsigned VFRONT  = 5,
   parameter int unsigned HW      = $clog2(timing_total(HSYNC, HBACK, HACTIVE, HFRONT) + 1),
   parameter int unsigned VW      = $clog2(timing_total(VSYNC, VBACK, VACTIVE, VFRONT) + 1)
) (
   input  logic          clock,
   input  logic          reset,
   output logic          hsync_c,
   output logic          vsync_c,
   output logic          de_c,
   output logic          v_active_c,
   output logic          frame_start_c,
   output logic [HW-1:0] x_c,
   output logic [VW-1:0] y_c
);

   localparam int unsigned HTOTAL = timing_total(HSYNC, HBACK, HACTIVE, HFRONT);
   localparam int unsigned VTOTAL = timing_total(VSYNC, VBACK, VACTIVE, VFRONT);
   localparam int unsigned HSTART = timing_start(HSYNC, HBACK);
   localparam int unsigned VSTART = timing_start(VSYNC, VBACK);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_active;

   // Counter advance: v steps when h wraps.
   always_comb begin
      h_d = h_q + HW'(1);
      v_d = v_q;
      if (h_q == HW'(HTOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == VW'(VTOTAL - 1)) ? '0 : v_q + VW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Region decode of the current counter value.
   always_comb begin
      h_active      = (h_q >= HW'(HSTART)) && (h_q < HW'(HSTART + HACTIVE));
      v_active_c    = (v_q >= VW'(VSTART)) && (v_q < VW'(VSTART + VACTIVE));
      hsync_c       = h_q < HW'(HSYNC);
      vsync_c       = v_q < VW'(VSYNC);
      de_c          = h_active && v_active_c;
      frame_start_c = (h_q == '0) && (v_q == '0);
      x_c           = h_q - HW'(HSTART);
      y_c           = v_q - VW'(VSTART);
   end

endmodule

// File: rtl/wave_plot_generator.sv
// wave_plot_generator: scrolling logic-analyser video source. Samples enter a
// DEPTH-entry circular buffer over valid/ready (vertical blanking only); each
// sample is drawn as one COL_W-pixel column, each channel as a square wave in
// its own ROW_H-pixel lane. Video outputs lag the timing counters by 2 clocks.
// Optional feature: define WAVE_PLOT_GRID_EN to draw a background grid.
// Ports:
//   clock, reset                 pixel clock, synchronous active-high reset
//   sample_valid, sample_data    incoming sample, one bit per channel
//   sample_ready                 sample accepted when valid && ready
//   freeze                       hold display, refuse samples
//   video_data                   RGB888, 0 outside de
//   video_de/hsync/vsync         active-high, registered
module wave_plot_generator
   import wave_plot_pkg::*;
#(
   parameter int unsigned HSYNC    = 40,
   parameter int unsigned HBACK    = 220,
   parameter int unsigned HACTIVE  = 1280,
   parameter int unsigned HFRONT   = 110,
   parameter int unsigned VSYNC    = 5,
   parameter int unsigned VBACK    = 20,
   parameter int unsigned VACTIVE  = 720,
   parameter int unsigned VFRONT   = 5,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned COL_W    = 4,
   parameter int unsigned ROW_H    = 64,
   parameter int unsigned TOP      = 100,
   parameter int unsigned HIGH_OFF = 8,
   parameter int unsigned LOW_OFF  = 48
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [CHANNELS-1:0] sample_data,
   output logic                sample_ready,
   input  logic                freeze,
   output logic [23:0]         video_data,
   output logic                video_de,
   output logic                video_hsync,
   output logic                video_vsync
);

   localparam int unsigned HW       = $clog2(timing_total(HSYNC, HBACK, HACTIVE, HFRONT) + 1);
   localparam int unsigned VW       = $clog2(timing_total(VSYNC, VBACK, VACTIVE, VFRONT) + 1);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned AW1      = AW + 1;
   localparam int unsigned FW       = $clog2(DEPTH + 1);
   localparam int unsigned CSH      = $clog2(COL_W);
   localparam int unsigned RSH      = $clog2(ROW_H);
   localparam int unsigned LYW      = RSH;
   localparam int unsigned PLOT_W   = DEPTH * COL_W;
   localparam int unsigned PLOT_BOT = TOP + CHANNELS * ROW_H;

   // Parameter sanity checks at elaboration.
   if (DEPTH * COL_W > HACTIVE) begin : g_err_plot_w
      $error("wave_plot_generator: DEPTH*COL_W exceeds HACTIVE");
   end
   if (TOP + CHANNELS * ROW_H > VACTIVE) begin : g_err_plot_h
      $error("wave_plot_generator: lanes extend past VACTIVE");
   end
   if (COL_W == 0 || (COL_W & (COL_W - 1)) != 0) begin : g_err_col_w
      $error("wave_plot_generator: COL_W must be a power of two");
   end
   if (ROW_H < 2 || (ROW_H & (ROW_H - 1)) != 0) begin : g_err_row_h
      $error("wave_plot_generator: ROW_H must be a power of two");
   end
   if (CHANNELS == 0 || CHANNELS > 8) begin : g_err_chan
      $error("wave_plot_generator: CHANNELS must be 1..8");
   end
   if (!(HIGH_OFF < LOW_OFF && LOW_OFF < ROW_H)) begin : g_err_offs
      $error("wave_plot_generator: need HIGH_OFF < LOW_OFF < ROW_H");
   end
   if (DEPTH < 2) begin : g_err_depth
      $error("wave_plot_generator: DEPTH must be at least 2");
   end

   // ---------------------------------------------------------------- timing
   logic          hsync_c, vsync_c, de_c, v_active_c, frame_start_c;
   logic [HW-1:0] x_c;
   logic [VW-1:0] y_c;

   video_timing_gen #(
      .HSYNC(HSYNC), .HBACK(HBACK), .HACTIVE(HACTIVE), .HFRONT(HFRONT),
      .VSYNC(VSYNC), .VBACK(VBACK), .VACTIVE(VACTIVE), .VFRONT(VFRONT),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clock        (clock),
      .reset        (reset),
      .hsync_c      (hsync_c),
      .vsync_c      (vsync_c),
      .de_c         (de_c),
      .v_active_c   (v_active_c),
      .frame_start_c(frame_start_c),
      .x_c          (x_c),
      .y_c          (y_c)
   );

   // ------------------------------------------------------ write handshake
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [AW-1:0] base_q, base_d;
   logic [FW-1:0] nfill_q, nfill_d;
   logic          wr_en;

   // Writes only in vertical blanking so a frame never tears.
   assign sample_ready = !reset && !freeze && !v_active_c;
   assign wr_en        = sample_valid && sample_ready;

   // Pointer/fill update and per-frame snapshot (pre-update values).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      base_d   = base_q;
      nfill_d  = nfill_q;
      if (wr_en) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
         if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
      end
      if (frame_start_c) begin
         base_d  = wr_ptr_q;
         nfill_d = fill_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         base_q   <= '0;
         nfill_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         base_q   <= base_d;
         nfill_q  <= nfill_d;
      end
   end

   // --------------------------------------------------------- sample RAM
   logic [CHANNELS-1:0] mem [DEPTH];
   logic [CHANNELS-1:0] rd_data_q;
   logic [AW-1:0]       rd_addr;

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr_q] <= sample_data;
      rd_data_q <= mem[rd_addr];
   end

   // ------------------------------------- stage 1: address and lane decode
   int unsigned    col_i;
   logic [AW:0]    addr_sum;
   logic           de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic           plot1_q, plot1_d, cval1_q, cval1_d, pval1_q, pval1_d;
   logic           first1_q, first1_d, last1_q, last1_d;
   logic [2:0]     lane1_q, lane1_d;
   logic [LYW-1:0] ly1_q, ly1_d;
`ifdef WAVE_PLOT_GRID_EN
   logic           grid1_q, grid1_d;
`endif

   always_comb begin
      col_i    = 32'(x_c) >> CSH;
      // Oldest sample sits at base, so column c maps to (base + c) mod DEPTH.
      addr_sum = AW1'(base_q) + AW1'(col_i);
      if (addr_sum >= AW1'(DEPTH)) addr_sum = addr_sum - AW1'(DEPTH);
      rd_addr  = AW'(addr_sum);

      de1_d    = de_c;
      hs1_d    = hsync_c;
      vs1_d    = vsync_c;
      plot1_d  = de_c && (32'(x_c) < PLOT_W) &&
                 (32'(y_c) >= TOP) && (32'(y_c) < PLOT_BOT);
      lane1_d  = 3'((32'(y_c) - TOP) >> RSH);
      ly1_d    = LYW'(32'(y_c) - TOP);
      // Newest nfill columns are right-aligned: valid iff c >= DEPTH - nfill.
      cval1_d  = (col_i + 32'(nfill_q)) >= DEPTH;
      pval1_d  = (col_i != 0) && ((col_i - 1 + 32'(nfill_q)) >= DEPTH);
      first1_d = (32'(x_c) & (COL_W - 1)) == 0;
      last1_d  = (32'(x_c) & (COL_W - 1)) == (COL_W - 1);
`ifdef WAVE_PLOT_GRID_EN
      grid1_d  = ((32'(x_c) & (16 * COL_W - 1)) == 0) || (ly1_d == '0);
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         de1_q    <= 1'b0;
         hs1_q    <= 1'b0;
         vs1_q    <= 1'b0;
         plot1_q  <= 1'b0;
         cval1_q  <= 1'b0;
         pval1_q  <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         lane1_q  <= '0;
         ly1_q    <= '0;
`ifdef WAVE_PLOT_GRID_EN
         grid1_q  <= 1'b0;
`endif
      end else begin
         de1_q    <= de1_d;
         hs1_q    <= hs1_d;
         vs1_q    <= vs1_d;
         plot1_q  <= plot1_d;
         cval1_q  <= cval1_d;
         pval1_q  <= pval1_d;
         first1_q <= first1_d;
         last1_q  <= last1_d;
         lane1_q  <= lane1_d;
         ly1_q    <= ly1_d;
`ifdef WAVE_PLOT_GRID_EN
         grid1_q  <= grid1_d;
`endif
      end
   end

   // --------------------------------------------- stage 2: pixel select
   logic [CHANNELS-1:0] prev_q, prev_d;
   logic [7:0]          cur_bits, prev_bits;
   logic                cur_b, prev_b;
   rgb_t                lane_colour, pix;
   logic [23:0]         video_data_q, video_data_d;
   logic                video_de_q, video_hsync_q, video_vsync_q;

   always_comb begin
      cur_bits    = 8'(rd_data_q);
      prev_bits   = 8'(prev_q);
      cur_b       = cur_bits[lane1_q];
      prev_b      = prev_bits[lane1_q];
      lane_colour = PALETTE[lane1_q];
      pix         = BG_COLOUR;
`ifdef WAVE_PLOT_GRID_EN
      if (plot1_q && grid1_q) pix = GRID_COLOUR;
`endif
      if (plot1_q && cval1_q) begin
         if (first1_q && pval1_q && (cur_b != prev_b) &&
             (ly1_q >= LYW'(HIGH_OFF)) && (ly1_q <= LYW'(LOW_OFF))) begin
            pix = lane_colour;
         end else if (ly1_q == (cur_b ? LYW'(HIGH_OFF) : LYW'(LOW_OFF))) begin
            pix = lane_colour;
         end
      end
      video_data_d = de1_q ? pix : 24'h0;
      // Columns are scanned left to right, so the previous column's bits are
      // captured on its last pixel and used for the edge at the next column.
      prev_d       = last1_q ? rd_data_q : prev_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         video_data_q  <= '0;
         video_de_q    <= 1'b0;
         video_hsync_q <= 1'b0;
         video_vsync_q <= 1'b0;
         prev_q        <= '0;
      end else begin
         video_data_q  <= video_data_d;
         video_de_q    <= de1_q;
         video_hsync_q <= hs1_q;
         video_vsync_q <= vs1_q;
         prev_q        <= prev_d;
      end
   end

   assign video_data  = video_data_q;
   assign video_de    = video_de_q;
   assign video_hsync = video_hsync_q;
   assign video_vsync = video_vsync_q;

endmodule

// File: tb/tb_wave_plot_generator.sv
// Self-checking bench for wave_plot_generator on a reduced timing: every cycle
// the ready output and the {de,hsync,vsync,data} word are compared against a
// reference built from the sample history and the frame-start snapshot.
module tb_wave_plot_generator;

   localparam int HT = 76;
   localparam int VT = 54;
   localparam int FR = HT * VT;
   localparam logic [23:0] BG   = 24'heeeeee;
   localparam logic [23:0] PAL0 = 24'hd62728;
   localparam logic [23:0] PAL1 = 24'h1f77b4;

   logic        clock = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [1:0]  sample_data;
   logic        sample_ready;
   logic        freeze;
   logic [23:0] video_data;
   logic        video_de, video_hsync, video_vsync;

   always #5 clock = ~clock;

   wave_plot_generator #(
      .HSYNC(4), .HBACK(4), .HACTIVE(64), .HFRONT(4),
      .VSYNC(2), .VBACK(2), .VACTIVE(48), .VFRONT(2),
      .CHANNELS(2), .DEPTH(16), .COL_W(4), .ROW_H(16), .TOP(8),
      .HIGH_OFF(2), .LOW_OFF(12)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .sample_ready(sample_ready),
      .freeze      (freeze),
      .video_data  (video_data),
      .video_de    (video_de),
      .video_hsync (video_hsync),
      .video_vsync (video_vsync)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         m_cur    = 0;   // index of the counter value the DUT holds now
   int         snap     = 0;   // samples accepted before the current frame start
   logic [1:0] hist[$];        // all samples accepted since reset, in order
   logic [1:0] plan[$];        // samples still to be offered in bottom blanking

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at index %0d: got %h expected %h", tag, m_cur, got, exp);
      end
   endtask

   function automatic logic [23:0] lane_colour(input int k);
      return (k == 0) ? PAL0 : PAL1;
   endfunction

   // Pixel at active (x,y): column c shows the sample accepted (16-c) places
   // before the snapshot; columns with no such sample are background.
   function automatic logic [23:0] pix_ref(input int x, input int y);
      int   k, ly, c, j;
      logic b, pb;
      if (x >= 64 || y < 8 || y >= 40) return BG;
      k  = (y - 8) / 16;
      ly = (y - 8) % 16;
      c  = x / 4;
      j  = snap - 16 + c;
      if (j < 0) return BG;
      b = hist[j][k];
      if ((x % 4 == 0) && c > 0 && j >= 1) begin
         pb = hist[j-1][k];
         if (pb != b && ly >= 2 && ly <= 12) return lane_colour(k);
      end
      if (ly == (b ? 2 : 12)) return lane_colour(k);
      return BG;
   endfunction

   function automatic logic [26:0] vid_ref(input int m);
      int   h, v;
      logic de, hs, vs;
      h  = m % HT;
      v  = (m / HT) % VT;
      hs = (h < 4);
      vs = (v < 2);
      de = (h >= 8 && h < 72 && v >= 4 && v < 52);
      return {de, hs, vs, de ? pix_ref(h - 8, v - 4) : 24'h0};
   endfunction

   // One clock: check ready, update model, clock edge, check video.
   task automatic tick();
      int   h, v;
      logic rdy;
      #1;
      h   = m_cur % HT;
      v   = (m_cur / HT) % VT;
      rdy = !reset && !freeze && !(v >= 4 && v < 52);
      check_eq("ready", 32'(sample_ready), 32'(rdy));
      if (!reset) begin
         if (h == 0 && v == 0) snap = hist.size();
         if (sample_valid && rdy) begin
            hist.push_back(sample_data);
            if (plan.size() > 0) void'(plan.pop_front());
         end
      end
      @(posedge clock);
      if (reset) begin
         m_cur = 0;
         hist.delete();
         snap = 0;
      end else begin
         m_cur++;
      end
      #1;
      check_eq("video", 32'({video_de, video_hsync, video_vsync, video_data}),
               32'((m_cur >= 2) ? vid_ref(m_cur - 2) : 27'd0));
   endtask

   // Random inputs: planned samples offered in bottom blanking, blocked
   // attempts during active lines, random freeze everywhere.
   task automatic drive_tick();
      int v;
      v            = (m_cur / HT) % VT;
      freeze       = ($urandom_range(0, 7) == 0);
      sample_valid = 1'b0;
      sample_data  = 2'($urandom);
      if (v >= 52 && plan.size() > 0) begin
         sample_valid = ($urandom_range(0, 3) != 0);
         sample_data  = plan[0];
      end else if (v >= 4 && v < 52) begin
         sample_valid = ($urandom_range(0, 1) == 1);
      end
      tick();
   endtask

   task automatic run_to(input int target);
      while (m_cur < target) drive_tick();
   endtask

   task automatic do_reset(input int n);
      reset        = 1'b1;
      sample_valid = 1'b0;
      freeze       = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_data  = 2'b00;
      freeze       = 1'b0;

      // Empty frame, then 16 samples alternating on ch0, shown in frame 1.
      do_reset(4);
      for (int i = 0; i < 16; i++) plan.push_back({1'($urandom), 1'(i % 2)});
      run_to(2 * FR + 20 * HT + 30);

      // Reset mid-frame; 3 samples (partial plot), then 17 more (wrap).
      do_reset(3);
      for (int i = 0; i < 3; i++) plan.push_back(2'($urandom));
      run_to(FR + 10);
      for (int i = 0; i < 17; i++) plan.push_back(2'($urandom));
      run_to(3 * FR + 30 * HT + 7);

      // Reset mid-frame; 2 samples, then a write on the snapshot cycle.
      do_reset(3);
      for (int i = 0; i < 2; i++) plan.push_back(2'($urandom));
      run_to(FR);
      freeze       = 1'b0;
      sample_valid = 1'b1;
      sample_data  = 2'($urandom);
      tick();
      run_to(3 * FR + 5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
